hand_datapath: RTL
==================

# hand_datapath

Card-holding datapath for the baccarat table. It responds to the `load_pcard1..3` / `load_dcard1..3` strobes issued by `statemachine` by capturing the current dealt card into the addressed slot. From the captured cards it returns `pscore`, `dscore` and `pcard3`, the inputs `statemachine` uses for its decisions. It also tracks cards-per-hand and flags protocol violations on the load interface.

## Interface
Parameters:
- `RANK_W`, default 4: width of a card rank (ranks 1..13; 0 = empty slot).

Ports:
- `slow_clock`, input, 1: single clock; all state changes on the rising edge.
- `resetb`, input, 1: asynchronous reset, active-high.
- `new_card`, input, 4: rank of the card currently offered by the dealer. 1 = Ace, 11..13 = J/Q/K.
- `load_pcard1`, `load_pcard2`, `load_pcard3`, input, 1 each: capture `new_card` into player slot 1/2/3.
- `load_dcard1`, `load_dcard2`, `load_dcard3`, input, 1 each: capture `new_card` into dealer slot 1/2/3.
- `pcard3`, output, 4: baccarat value (0..9) of player card 3; 0 if slot empty.
- `pscore`, output, 4: player hand score 0..9.
- `dscore`, output, 4: dealer hand score 0..9.
- `pcount`, output, 2: number of player slots filled, 0..3.
- `dcount`, output, 2: number of dealer slots filled, 0..3.
- `load_error`, output, 1: sticky protocol-violation flag.

## Operation
- **State:** six 4-bit slot registers (`p1`, `p2`, `p3`, `d1`, `d2`, `d3`), six valid bits, and a `load_error` flop.
- **Card value:** rank 1..9 gives value = rank; rank 10..13 gives value 0; empty slot gives 0.
- **Scores:**
  - `pscore` = (v(p1) + v(p2) + v(p3)) mod 10. The sum is at most 27; use a 5-bit intermediate and reduce by conditional subtraction of 10 or 20. No divider.
  - `dscore` is computed the same way from the dealer slots.
- **Derived outputs:** `pcard3` = v(p3). `pcount`/`dcount` = popcount of the hand's valid bits.
- **Accepted load:** exactly one load strobe is high on the edge and none of the error conditions below applies. The slot takes `new_card` and its valid bit sets.
- **Error conditions.** On an edge where any load is high, each of the following is an error:
  - (a) more than one load strobe is high;
  - (b) `new_card` is 0, 14 or 15;
  - (c) the target slot is already valid;
  - (d) order violation: card 2 loaded while card 1 of the same hand is empty, or card 3 loaded while card 2 is empty.
- **On an error:** no slot or valid bit changes, and `load_error` sets.
- **`load_error` lifetime:** it stays set until reset; later legal loads are still accepted.
- **Player/dealer interleaving** is not checked. `statemachine` owns that order.
- **No load high:** all registers hold.

## Timing
- **Reset** (async, immediate on `resetb`=1) clears all slots to 0, all valid bits to 0 and `load_error` to 0. Resulting outputs: `pscore` = `dscore` = `pcard3` = 0, `pcount` = `dcount` = 0, `load_error` = 0.
- **Reset while a load is high:** reset wins and nothing is captured.
- **Load latency:** a load strobe high at rising edge N updates the slot at edge N.
- **Output latency:** `pscore`, `dscore`, `pcard3`, `pcount` and `dcount` are combinational from the slot registers. They show the new card in the cycle after edge N, which is the cycle in which `statemachine` evaluates its next transition. No additional pipeline delay is permitted.
- **`load_error`** is registered and is high starting the cycle after the offending edge.
- **`new_card` sampling:** sampled only on edges with a load high; its value at other times is don't-care.
- **Strobe width:** a load strobe held high for two consecutive edges triggers error (c) on the second edge.
- **Deassert of `resetb`:** the first edge with `resetb`=0 may already accept a load.

## Test plan
- **Reset values:** assert `resetb` mid-hand (after p1=7 and d1=3 are loaded) → `pscore`=0, `dscore`=0, `pcard3`=0, `pcount`=0, `dcount`=0 and `load_error`=0 immediately, without waiting for a clock edge.
- **Four-card deal with face cards:** load, on successive edges, p1=5, d1=10, p2=13, d2=4 → after the final edge `pscore`=5, `dscore`=4, `pcount`=2, `dcount`=2, `load_error`=0.
- **Third cards and mod-10 wrap:** continue the previous deal with p3=8 then d3=9 → `pcard3`=8, `pscore`=3, `dscore`=3, `pcount`=3, `dcount`=3.
- **Natural:** load p1=4, p2=5, d1=1, d2=7 → `pscore`=9 and `dscore`=8; `pcard3` stays 0.
- **Protocol errors, each from reset:**
  - `load_pcard2` with p1 empty → slot unchanged, `pcount`=0, `load_error`=1 next cycle.
  - `load_pcard1` and `load_dcard1` high together → both ignored, `load_error`=1.
  - `load_pcard1` with `new_card`=14 → ignored, `load_error`=1.
  - `load_pcard1` held high for 2 edges → p1 captured once, `load_error`=1.
- **Sticky error:** after an error, a legal load of p1=6 is accepted → `pscore`=6 and `load_error` remains 1 until reset.

Source files
------------

// File: rtl/hand_datapath.sv
// Holds the player and dealer cards for one baccarat round and derives the
// hand scores, card counts and a sticky load-protocol error flag.
module hand_datapath #(
  parameter int RANK_W = 4
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic [RANK_W-1:0] new_card,
  input  logic              load_pcard1,
  input  logic              load_pcard2,
  input  logic              load_pcard3,
  input  logic              load_dcard1,
  input  logic              load_dcard2,
  input  logic              load_dcard3,
  output logic [3:0]        pcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore,
  output logic [1:0]        pcount,
  output logic [1:0]        dcount,
  output logic              load_error
);

  // Slot order: 0..2 are player cards 1..3, 3..5 are dealer cards 1..3.
  logic [RANK_W-1:0] slot [6];
  logic [5:0]        valid;
  logic [5:0]        loads;
  logic [5:0]        prereq;
  logic              any_load;
  logic              multi_load;
  logic              bad_card;
  logic              occupied;
  logic              order_err;
  logic              load_bad;
  logic [4:0]        psum;
  logic [4:0]        dsum;

  function automatic logic [3:0] card_value(input logic [RANK_W-1:0] rank);
    card_value = (rank >= RANK_W'(1) && rank <= RANK_W'(9)) ? 4'(rank) : 4'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] sum);
    if (sum >= 5'd20)
      mod10 = 4'(sum - 5'd20);
    else if (sum >= 5'd10)
      mod10 = 4'(sum - 5'd10);
    else
      mod10 = sum[3:0];
  endfunction

  assign loads = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

  // A card 2 or 3 may only go in once the previous card of that hand is present.
  assign prereq     = {valid[4], valid[3], 1'b1, valid[1], valid[0], 1'b1};
  assign any_load   = |loads;
  assign multi_load = |(loads & (loads - 6'd1));
  assign bad_card   = (new_card == '0) || (new_card > RANK_W'(13));
  assign occupied   = |(loads & valid);
  assign order_err  = |(loads & ~prereq);
  assign load_bad   = any_load && (multi_load || bad_card || occupied || order_err);

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      for (int i = 0; i < 6; i++) slot[i] <= '0;
      valid      <= '0;
      load_error <= 1'b0;
    end else if (any_load) begin
      if (load_bad) begin
        load_error <= 1'b1;
      end else begin
        for (int i = 0; i < 6; i++)
          if (loads[i]) slot[i] <= new_card;
        valid <= valid | loads;
      end
    end
  end

  assign psum = 5'(card_value(slot[0])) + 5'(card_value(slot[1])) + 5'(card_value(slot[2]));
  assign dsum = 5'(card_value(slot[3])) + 5'(card_value(slot[4])) + 5'(card_value(slot[5]));

  assign pscore = mod10(psum);
  assign dscore = mod10(dsum);
  assign pcard3 = card_value(slot[2]);
  assign pcount = 2'(valid[0]) + 2'(valid[1]) + 2'(valid[2]);
  assign dcount = 2'(valid[3]) + 2'(valid[4]) + 2'(valid[5]);

endmodule
